exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Execute/memory slice of the 16-bit single-cycle CPU: instruction decode (control), 16-bit ALU, data RAM with memory-mapped LED/7-segment I/O, and the operand/write-back/next-PC selection.
- Sits between the register file/instruction ROM and the PC.
- Fully combinational except RAM writes, I/O registers and the display scanner.

Parameters:
- DEPTH, 256, data RAM words (word index = alu result[7:0]).
- SCAN_DIV, 50000, clock cycles per display digit.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- run_en  in  1  CPU running; gates all architectural writes.
- op  in  4  instruction opcode.
- rd1  in  16  register rs value.
- rd2  in  16  register rt value (store data / ALU operand).
- imm_ext  in  16  extended immediate.
- pc_cur  in  16  current PC (byte address).
- rom_data  in  16  word returned by instruction ROM for rom_addr.
- wb_data  out  16  register write-back data.
- wreg_en  out  1  register write enable (already ANDed with run_en).
- pc_next  out  16  next PC.
- rom_addr  out  16  ROM data-read address.
- zero  out  1  ALU result == 0.
- led  out  4  led[0]=led1 .. led[3]=led4, active-high.
- seg  out  7  segments a..g = seg[6:0], active-low (common anode).
- sel  out  6  digit selects DIG1..DIG6 = sel[0]..sel[5], active-low.

Behaviour:
- Decode (op → ALUOp, alucsrc, wreg, wmem, memc, m2reg, PCsrc):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT: B = rd2, wreg = 1, wb = alu.
  - 8 ADDI: B = imm, ADD, wb = alu.
  - 9 LW: B = imm, ADD, wb = mem.
  - A SW: B = imm, ADD, wmem = 1, wreg = 0.
  - B LROM: B = imm, ADD, memc = 1, wb = mem (rom_data).
  - C LUI: wb = imm_ext.
  - D BEQ: B = rd2, SUB, wreg = 0; taken if zero.
  - E BNE: B = rd2, SUB, wreg = 0; taken if !zero.
  - F JAL: wb = pc_cur + 2, pc_next = pc_cur + imm_ext, wreg = 1.
- ALUOp encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL by B[3:0], 110 SRL (logical) by B[3:0], 111 SLT (signed, result 1 or 0).
- ALU A = rd1. Arithmetic is mod 2^16; overflow is ignored. zero = (result == 16'h0000).
- pc_next: pc_cur + 2 by default; pc_cur + imm_ext for a taken branch or JAL. There is no register-indirect jump.
- rom_addr = alu result at all times. For LROM, the memory read data is rom_data.
- Memory map (address = alu result):
  - 16'hFFF0: LED register, bits [3:0].
  - 16'hFFF2: display register, 16 bits.
  - All other addresses: RAM[result[7:0]], aliased; DEPTH = 256.
- Reads are combinational. I/O addresses read back the register value zero-extended.
- Writes occur on the rising CLK edge when op = SW and run_en = 1. No write ever happens when run_en = 0.
- Reset (RESET = 0 at CLK edge):
  - LED register = 0, display register = 0, scan counter = 0, digit index = 0.
  - sel = 6'b111111, seg = 7'b1111111 for that cycle.
  - RAM contents are not cleared.
  - Reset has priority over a simultaneous write.
- Display:
  - Digit index 0..3 shows display[15:12], [11:8], [7:4], [3:0] on DIG1..DIG4; DIG5 and DIG6 are always off.
  - Exactly one sel bit is low when active. The digit advances every SCAN_DIV cycles and wraps 3 → 0.
  - Hex patterns (abcdefg, active-low): 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- wreg_en = wreg & run_en. Outputs are undefined-free: every op maps to defined controls.

Test Plan:
- op = 0, rd1 = 16'h7FFF, rd2 = 1 → wb_data = 16'h8000, zero = 0, wreg_en = 1, pc_next = pc_cur + 2.
- op = 7 with rd1 = 16'hFFFF, rd2 = 1 → wb = 1; op = 5 with rd1 = 1, rd2 = 16'h0013 → wb = 16'h0008.
- SW rd1 = 4, imm = 1, rd2 = 16'hBEEF, run_en = 1; then LW same address → wb = 16'hBEEF. Repeat SW with run_en = 0 → RAM unchanged.
- BEQ rd1 = rd2 = 5, imm = 16'hFFFC, pc_cur = 16'h0010 → pc_next = 16'h000C, wreg_en = 0. BNE same operands → pc_next = 16'h0012.
- SW to 16'hFFF0 data 16'h000A → led = 4'b1010. SW to 16'hFFF2 data 16'h1234 → DIG1 shows 1 (seg 1001111, sel 111110), then advances to "2" after SCAN_DIV cycles. Reset → led = 0 and all digits off.
- JAL pc_cur = 16'h0020, imm = 16'h0010 → pc_next = 16'h0030, wb = 16'h0022. LROM rd1 = 3, imm = 2 → rom_addr = 5, wb = rom_data.

Source files
------------

// File: rtl/exec_mem_unit_if.sv
// CPU-side bus of the execute/memory slice: operands and opcode from the
// register file and decoder, plus write-back, next-PC and ROM read results.
interface exec_mem_unit_if;
  logic        run_en;
  logic [3:0]  op;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] imm_ext;
  logic [15:0] pc_cur;
  logic [15:0] rom_data;
  logic [15:0] wb_data;
  logic        wreg_en;
  logic [15:0] pc_next;
  logic [15:0] rom_addr;
  logic        zero;

  // The CPU core drives operands and consumes results.
  modport master (
    output run_en, op, rd1, rd2, imm_ext, pc_cur, rom_data,
    input  wb_data, wreg_en, pc_next, rom_addr, zero
  );

  // The execute/memory slice consumes operands and produces results.
  modport slave (
    input  run_en, op, rd1, rd2, imm_ext, pc_cur, rom_data,
    output wb_data, wreg_en, pc_next, rom_addr, zero
  );
endinterface

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the 16-bit single-cycle CPU: decode, ALU, data RAM
// with memory-mapped LED and 7-segment registers, write-back and next-PC mux.
// Only RAM writes, the I/O registers and the display scanner hold state.
module exec_mem_unit #(
  parameter int DEPTH    = 256,
  parameter int SCAN_DIV = 50000
) (
  input  logic           CLK,
  input  logic           RESET,
  exec_mem_unit_if.slave bus,
  output logic [3:0]     led,
  output logic [6:0]     seg,
  output logic [5:0]     sel
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SLT  = 4'h7,
    OP_ADDI = 4'h8, OP_LW   = 4'h9, OP_SW   = 4'hA, OP_LROM = 4'hB,
    OP_LUI  = 4'hC, OP_BEQ  = 4'hD, OP_BNE  = 4'hE, OP_JAL  = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
    ALU_XOR = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_IMM, WB_LINK
  } wb_sel_e;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LED_ADDR  = 16'hFFF0;
  localparam logic [15:0] DISP_ADDR = 16'hFFF2;
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

  // Decode outputs
  alu_op_e     alu_op;
  logic        alucsrc;
  logic        wreg;
  logic        wmem;
  logic        memc;
  wb_sel_e     wb_sel;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;

  // Datapath
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [15:0] mem_rdata;
  logic [15:0] pc_plus2;
  logic [15:0] pc_target;
  logic        take_branch;
  logic        is_led;
  logic        is_disp;
  logic        mem_we;
  logic [AW-1:0] ram_idx;

  // State
  logic [15:0] ram [DEPTH];
  logic [3:0]  led_reg;
  logic [15:0] disp_reg;
  logic [31:0] scan_cnt;
  logic [1:0]  digit;
  logic [3:0]  nibble;

  // Translate the opcode into datapath controls; every opcode is covered.
  always_comb begin
    alu_op    = ALU_ADD;
    alucsrc   = 1'b0;
    wreg      = 1'b0;
    wmem      = 1'b0;
    memc      = 1'b0;
    wb_sel    = WB_ALU;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    case (op_e'(bus.op))
      OP_ADD:  begin alu_op = ALU_ADD; wreg = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; wreg = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; wreg = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  wreg = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; wreg = 1'b1; end
      OP_SLL:  begin alu_op = ALU_SLL; wreg = 1'b1; end
      OP_SRL:  begin alu_op = ALU_SRL; wreg = 1'b1; end
      OP_SLT:  begin alu_op = ALU_SLT; wreg = 1'b1; end
      OP_ADDI: begin alucsrc = 1'b1; wreg = 1'b1; end
      OP_LW:   begin alucsrc = 1'b1; wreg = 1'b1; wb_sel = WB_MEM; end
      OP_SW:   begin alucsrc = 1'b1; wmem = 1'b1; end
      OP_LROM: begin alucsrc = 1'b1; wreg = 1'b1; memc = 1'b1; wb_sel = WB_MEM; end
      OP_LUI:  begin wreg = 1'b1; wb_sel = WB_IMM; end
      OP_BEQ:  begin alu_op = ALU_SUB; branch_eq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; branch_ne = 1'b1; end
      OP_JAL:  begin wreg = 1'b1; wb_sel = WB_LINK; jump = 1'b1; end
      default: begin end
    endcase
  end

  // ALU: A is always rs, B is rt or the immediate; shifts use B[3:0].
  always_comb begin
    alu_b = alucsrc ? bus.imm_ext : bus.rd2;
    case (alu_op)
      ALU_ADD: alu_result = bus.rd1 + alu_b;
      ALU_SUB: alu_result = bus.rd1 - alu_b;
      ALU_AND: alu_result = bus.rd1 & alu_b;
      ALU_OR:  alu_result = bus.rd1 | alu_b;
      ALU_XOR: alu_result = bus.rd1 ^ alu_b;
      ALU_SLL: alu_result = bus.rd1 << alu_b[3:0];
      ALU_SRL: alu_result = bus.rd1 >> alu_b[3:0];
      ALU_SLT: alu_result = {15'b0, ($signed(bus.rd1) < $signed(alu_b))};
      default: alu_result = 16'h0000;
    endcase
  end

  // Address decode and combinational read; LROM reads come from the ROM port.
  always_comb begin
    ram_idx = alu_result[AW-1:0];
    is_led  = (alu_result == LED_ADDR);
    is_disp = (alu_result == DISP_ADDR);
    if (memc)
      mem_rdata = bus.rom_data;
    else if (is_led)
      mem_rdata = {12'b0, led_reg};
    else if (is_disp)
      mem_rdata = disp_reg;
    else
      mem_rdata = ram[ram_idx];
  end

  // Write-back select, next PC and the remaining bus outputs.
  always_comb begin
    pc_plus2    = bus.pc_cur + 16'd2;
    pc_target   = bus.pc_cur + bus.imm_ext;
    take_branch = jump | (branch_eq & (alu_result == 16'h0000))
                       | (branch_ne & (alu_result != 16'h0000));
    mem_we      = wmem & bus.run_en;
    case (wb_sel)
      WB_ALU:  bus.wb_data = alu_result;
      WB_MEM:  bus.wb_data = mem_rdata;
      WB_IMM:  bus.wb_data = bus.imm_ext;
      WB_LINK: bus.wb_data = pc_plus2;
      default: bus.wb_data = alu_result;
    endcase
    bus.pc_next  = take_branch ? pc_target : pc_plus2;
    bus.wreg_en  = wreg & bus.run_en;
    bus.rom_addr = alu_result;
    bus.zero     = (alu_result == 16'h0000);
  end

  // Memory-mapped LED and display registers; reset wins over a store.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      led_reg  <= 4'h0;
      disp_reg <= 16'h0000;
    end else if (mem_we) begin
      if (is_led)
        led_reg <= bus.rd2[3:0];
      else if (is_disp)
        disp_reg <= bus.rd2;
    end
  end

  // Data RAM store; contents survive reset but no store happens during it.
  always_ff @(posedge CLK) begin
    if (RESET && mem_we && !is_led && !is_disp)
      ram[ram_idx] <= bus.rd2;
  end

  // Display scanner: hold each digit for SCAN_DIV cycles, cycling 0..3.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      scan_cnt <= 32'd0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 32'd0;
      digit    <= (digit == 2'd3) ? 2'd0 : digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  // Drive the active digit (DIG5/DIG6 stay dark); blank everything in reset.
  always_comb begin
    case (digit)
      2'd0:    begin nibble = disp_reg[15:12]; sel = 6'b111110; end
      2'd1:    begin nibble = disp_reg[11:8];  sel = 6'b111101; end
      2'd2:    begin nibble = disp_reg[7:4];   sel = 6'b111011; end
      default: begin nibble = disp_reg[3:0];   sel = 6'b110111; end
    endcase
    seg = hex_to_seg(nibble);
    if (!RESET) begin
      sel = 6'b111111;
      seg = 7'b1111111;
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: table of single-cycle vectors plus
// hand sequences for stores, I/O registers, reset and the display scanner.
module tb_exec_mem_unit;

  localparam int SCAN = 4;

  logic       CLK;
  logic       RESET;
  logic [3:0] led;
  logic [6:0] seg;
  logic [5:0] sel;

  exec_mem_unit_if bus_if ();

  exec_mem_unit #(.DEPTH(256), .SCAN_DIV(SCAN)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if),
    .led   (led),
    .seg   (seg),
    .sel   (sel)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic        run;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] rom;
    logic [15:0] wb;
    logic        wreg;
    logic [15:0] pcn;
    logic [15:0] raddr;
    logic        zero;
    logic        chk_wb;
    logic        chk_alu;
  } vec_t;

  typedef struct {
    int          tag;
    logic [15:0] wb;
    logic        wreg;
    logic [15:0] pcn;
    logic [15:0] raddr;
    logic        zero;
    logic        chk_wb;
    logic        chk_alu;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_next = 0;

  vec_t       vecs [20];
  logic [6:0] exp_seg [4];
  logic [5:0] exp_sel [4];

  task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus_if.op       = v.op;
    bus_if.run_en   = v.run;
    bus_if.rd1      = v.rd1;
    bus_if.rd2      = v.rd2;
    bus_if.imm_ext  = v.imm;
    bus_if.pc_cur   = v.pc;
    bus_if.rom_data = v.rom;
    e.tag     = tag_next;
    e.wb      = v.wb;
    e.wreg    = v.wreg;
    e.pcn     = v.pcn;
    e.raddr   = v.raddr;
    e.zero    = v.zero;
    e.chk_wb  = v.chk_wb;
    e.chk_alu = v.chk_alu;
    sb_q.push_back(e);
    tag_next++;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb_q.pop_front();
    checkValue($sformatf("v%0d pc_next", e.tag), bus_if.pc_next, e.pcn);
    checkValue($sformatf("v%0d wreg_en", e.tag), {15'b0, bus_if.wreg_en}, {15'b0, e.wreg});
    if (e.chk_wb)
      checkValue($sformatf("v%0d wb_data", e.tag), bus_if.wb_data, e.wb);
    if (e.chk_alu) begin
      checkValue($sformatf("v%0d rom_addr", e.tag), bus_if.rom_addr, e.raddr);
      checkValue($sformatf("v%0d zero", e.tag), {15'b0, bus_if.zero}, {15'b0, e.zero});
    end
  endtask

  // One vector per falling edge, checked 1 time unit later.
  task automatic runVec(input vec_t v);
    @(negedge CLK);
    applyStimulus(v);
    #1;
    checkOutput();
  endtask

  task automatic idleBus();
    bus_if.op       = 4'h0;
    bus_if.run_en   = 1'b0;
    bus_if.rd1      = 16'h0000;
    bus_if.rd2      = 16'h0000;
    bus_if.imm_ext  = 16'h0000;
    bus_if.pc_cur   = 16'h0000;
    bus_if.rom_data = 16'h0000;
  endtask

  initial begin
    logic [5:0] prev_sel;
    bit         found;

    //            op   run  rd1      rd2      imm      pc       rom      wb       wr  pcn      raddr    z  cwb ca
    vecs[0]  = '{4'h0, 1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0010, 16'h0000, 16'h8000, 1, 16'h0012, 16'h8000, 0, 1, 1};
    vecs[1]  = '{4'h1, 1, 16'h0005, 16'h0005, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0012, 16'h0000, 1, 1, 1};
    vecs[2]  = '{4'h2, 1, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h0010, 16'h0000, 16'h00F0, 1, 16'h0012, 16'h00F0, 0, 1, 1};
    vecs[3]  = '{4'h3, 1, 16'hF000, 16'h000F, 16'h0000, 16'h0010, 16'h0000, 16'hF00F, 1, 16'h0012, 16'hF00F, 0, 1, 1};
    vecs[4]  = '{4'h4, 1, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0010, 16'h0000, 16'hFF00, 1, 16'h0012, 16'hFF00, 0, 1, 1};
    vecs[5]  = '{4'h5, 1, 16'h0001, 16'h0013, 16'h0000, 16'h0010, 16'h0000, 16'h0008, 1, 16'h0012, 16'h0008, 0, 1, 1};
    vecs[6]  = '{4'h6, 1, 16'h8000, 16'h0004, 16'h0000, 16'h0010, 16'h0000, 16'h0800, 1, 16'h0012, 16'h0800, 0, 1, 1};
    vecs[7]  = '{4'h7, 1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0010, 16'h0000, 16'h0001, 1, 16'h0012, 16'h0001, 0, 1, 1};
    vecs[8]  = '{4'h7, 1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0012, 16'h0000, 1, 1, 1};
    vecs[9]  = '{4'h8, 1, 16'h0010, 16'h1234, 16'hFFFF, 16'h0010, 16'h0000, 16'h000F, 1, 16'h0012, 16'h000F, 0, 1, 1};
    vecs[10] = '{4'hC, 1, 16'h1111, 16'h2222, 16'hAB00, 16'h0010, 16'h0000, 16'hAB00, 1, 16'h0012, 16'h0000, 0, 1, 0};
    vecs[11] = '{4'hD, 1, 16'h0005, 16'h0005, 16'hFFFC, 16'h0010, 16'h0000, 16'h0000, 0, 16'h000C, 16'h0000, 1, 0, 1};
    vecs[12] = '{4'hE, 1, 16'h0005, 16'h0005, 16'hFFFC, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'h0000, 1, 0, 1};
    vecs[13] = '{4'hD, 1, 16'h0005, 16'h0006, 16'hFFFC, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'hFFFF, 0, 0, 1};
    vecs[14] = '{4'hE, 1, 16'h0005, 16'h0006, 16'hFFFC, 16'h0010, 16'h0000, 16'h0000, 0, 16'h000C, 16'hFFFF, 0, 0, 1};
    vecs[15] = '{4'hF, 1, 16'h0000, 16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0022, 1, 16'h0030, 16'h0000, 0, 1, 0};
    vecs[16] = '{4'hB, 1, 16'h0003, 16'h0000, 16'h0002, 16'h0010, 16'h5A5A, 16'h5A5A, 1, 16'h0012, 16'h0005, 0, 1, 1};
    vecs[17] = '{4'h0, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h0003, 0, 16'h0012, 16'h0003, 0, 1, 1};
    vecs[18] = '{4'h6, 1, 16'hFFFF, 16'h0014, 16'h0000, 16'h0010, 16'h0000, 16'h0FFF, 1, 16'h0012, 16'h0FFF, 0, 1, 1};
    vecs[19] = '{4'h5, 1, 16'h0003, 16'h000F, 16'h0000, 16'h0010, 16'h0000, 16'h8000, 1, 16'h0012, 16'h8000, 0, 1, 1};

    exp_seg[0] = 7'b1001111; exp_sel[0] = 6'b111110;
    exp_seg[1] = 7'b0010010; exp_sel[1] = 6'b111101;
    exp_seg[2] = 7'b0000110; exp_sel[2] = 6'b111011;
    exp_seg[3] = 7'b1001100; exp_sel[3] = 6'b110111;

    // Power-up reset
    idleBus();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkValue("reset led", {12'b0, led}, 16'h0000);
    checkValue("reset seg", {9'b0, seg}, 16'h007F);
    checkValue("reset sel", {10'b0, sel}, 16'h003F);
    RESET = 1'b1;
    #1;
    checkValue("post-reset sel", {10'b0, sel}, 16'h003E);
    checkValue("post-reset seg", {9'b0, seg}, 16'h0001);

    // Combinational vector table
    for (int i = 0; i < 20; i++) runVec(vecs[i]);

    // Store then load, store with run_en low, and RAM aliasing
    runVec('{4'hA, 1, 16'h0004, 16'hBEEF, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'h0005, 0, 0, 1});
    runVec('{4'h9, 1, 16'h0004, 16'h0000, 16'h0001, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h0012, 16'h0005, 0, 1, 1});
    runVec('{4'hA, 0, 16'h0004, 16'h1111, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'h0005, 0, 0, 1});
    runVec('{4'h9, 1, 16'h0004, 16'h0000, 16'h0001, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h0012, 16'h0005, 0, 1, 1});
    runVec('{4'h9, 1, 16'h0105, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h0012, 16'h0105, 0, 1, 1});

    // LED register: store, read back, ignored store with run_en low
    runVec('{4'hA, 1, 16'hFFF0, 16'h000A, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'hFFF0, 0, 0, 1});
    runVec('{4'h9, 1, 16'hFFF0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h000A, 1, 16'h0012, 16'hFFF0, 0, 1, 1});
    checkValue("led after store", {12'b0, led}, 16'h000A);
    runVec('{4'hA, 0, 16'hFFF0, 16'h0005, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'hFFF0, 0, 0, 1});
    @(negedge CLK);
    checkValue("led run_en low", {12'b0, led}, 16'h000A);

    // Display register and scanning
    runVec('{4'hA, 1, 16'hFFF0, 16'h1234, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0012, 16'hFFF2, 0, 0, 1});
    runVec('{4'h9, 1, 16'hFFF2, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0012, 16'hFFF2, 0, 1, 1});
    idleBus();
    prev_sel = sel;
    found = 1'b0;
    for (int c = 0; c < 6 * SCAN && !found; c++) begin
      @(posedge CLK);
      #1;
      if (sel == 6'b111110 && prev_sel == 6'b110111) found = 1'b1;
      prev_sel = sel;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL scan wrap: got no DIG4->DIG1 step expected one within %0d cycles", 6 * SCAN);
    end else begin
      for (int d = 0; d < 5; d++) begin
        checkValue($sformatf("digit%0d sel", d), {10'b0, sel}, {10'b0, exp_sel[d % 4]});
        checkValue($sformatf("digit%0d seg", d), {9'b0, seg}, {9'b0, exp_seg[d % 4]});
        repeat (SCAN - 1) @(posedge CLK);
        #1;
        checkValue($sformatf("digit%0d hold", d), {10'b0, sel}, {10'b0, exp_sel[d % 4]});
        @(posedge CLK);
        #1;
      end
    end

    // Reset with a simultaneous LED store: reset must win
    @(negedge CLK);
    RESET = 1'b0;
    bus_if.op      = 4'hA;
    bus_if.run_en  = 1'b1;
    bus_if.rd1     = 16'hFFF0;
    bus_if.rd2     = 16'h000F;
    bus_if.imm_ext = 16'h0000;
    #1;
    checkValue("reset blank sel", {10'b0, sel}, 16'h003F);
    checkValue("reset blank seg", {9'b0, seg}, 16'h007F);
    @(posedge CLK);
    #1;
    checkValue("reset led clear", {12'b0, led}, 16'h0000);
    @(negedge CLK);
    RESET = 1'b1;
    idleBus();
    runVec('{4'h9, 1, 16'hFFF2, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0012, 16'hFFF2, 0, 1, 1});
    runVec('{4'h9, 1, 16'h0005, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h0012, 16'h0005, 0, 1, 1});

    checkValue("scoreboard drained", 16'(sb_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
